// File: rtl/mux_16x1_rr_sched.sv
// Round-robin scheduler for the shared registered 16x1 mux: grants one requester for up to MAX_HOLD beats, then forces a one-cycle gap.
// Latency: grant and select register one edge after arbitration; y_valid_o is registered one edge after the accepting cycle.
module mux_16x1_rr_sched #(
    parameter int N        = 16,
    parameter int SEL_W    = $clog2(N),
    parameter int MAX_HOLD = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             rdy_i,
    output logic [SEL_W-1:0] s_o,
    output logic [N-1:0]     gnt_o,
    output logic             busy_o,
    output logic             y_valid_o
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

    localparam logic [7:0]   CNT_LAST = 8'(MAX_HOLD - 1);
    localparam logic [N-1:0] ONE_HOT0 = N'(1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             yv_q, yv_d;

    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W-1:0] scan_idx;
    logic             cur_req;

    // Scan from ptr upward; SEL_W-bit addition gives the mod-N wrap for free.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = ptr_q + SEL_W'(i);
            if (!win_found && req_i[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign cur_req = req_i[s_q];

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        yv_d    = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (win_found) begin
                    state_d = GRANT;
                    s_d     = win_idx;
                    gnt_d   = ONE_HOT0 << win_idx;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            GRANT: begin
                yv_d = rdy_i && cur_req;
                // A dropped request on the final beat is still a single release.
                if (!cur_req || (rdy_i && cnt_q == CNT_LAST)) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    ptr_d   = s_q + SEL_W'(1);
                end else if (rdy_i) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            s_q     <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            yv_q    <= yv_d;
        end
    end

    assign s_o       = s_q;
    assign gnt_o     = gnt_q;
    assign busy_o    = (state_q != IDLE);
    assign y_valid_o = yv_q;

endmodule

// File: tb/tb_mux_16x1_rr_sched.sv
// Directed plus randomized bench for mux_16x1_rr_sched against a cycle-level behavioural model.
module tb_mux_16x1_rr_sched;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        rdy;
    logic [3:0]  s;
    logic [15:0] gnt;
    logic        busy;
    logic        y_valid;

    int ncmp  = 0;
    int nfail = 0;
    int ycount = 0;

    // Model: who owns the mux (-1 = nobody), beats taken, gap flag, rotation start.
    int m_owner, m_beats, m_ptr, m_s;
    bit m_gap, m_yv;

    mux_16x1_rr_sched dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .rdy_i    (rdy),
        .s_o      (s),
        .gnt_o    (gnt),
        .busy_o   (busy),
        .y_valid_o(y_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int cur, j;
        if (rst) begin
            m_owner = -1; m_gap = 0; m_s = 0; m_ptr = 0; m_beats = 0; m_yv = 0;
        end else if (m_owner >= 0) begin
            cur  = m_owner;
            m_yv = rdy && req[cur];
            if (!req[cur] || (rdy && m_beats == MAX_HOLD - 1)) begin
                m_owner = -1;
                m_gap   = 1;
                m_ptr   = (cur + 1) % 16;
            end else if (rdy) begin
                m_beats++;
            end
        end else begin
            m_yv  = 0;
            m_gap = 0;
            for (int k = 0; k < 16; k++) begin
                j = (m_ptr + k) % 16;
                if (m_owner < 0 && req[j]) begin
                    m_owner = j;
                    m_s     = j;
                    m_beats = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        logic [15:0] exp_gnt;
        @(posedge clk);
        model_step();
        #1;
        exp_gnt = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("s", 32'(s), 32'(m_s));
        chk("busy", 32'(busy), 32'(m_owner >= 0 || m_gap));
        chk("y_valid", 32'(y_valid), 32'(m_yv));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (gnt != 16'h0) chk("gnt_at_s", 32'(gnt[s]), 32'd1);
        if (y_valid === 1'b1) ycount++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 16'hFFFF; rdy = 1'b1;
        m_owner = -1; m_gap = 0; m_s = 0; m_ptr = 0; m_beats = 0; m_yv = 0;

        // Reset held with every requester active
        cycle();
        cycle();
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);

        // Sole requester 4: eight beats, gap, re-grant
        rst = 1'b0; req = 16'h0010; rdy = 1'b1;
        cycle();
        chk("s2_first_gnt", 32'(gnt), 32'h0010);
        ycount = 0;
        for (int i = 0; i < 9; i++) cycle();
        chk("s2_pulses", 32'(ycount), 32'd8);
        chk("s2_regrant", 32'(gnt), 32'h0010);

        // Requesters 0 and 15 alternate with wrap
        req = 16'h0000;
        do_reset();
        req = 16'h8001;
        cycle();
        chk("s3_first", 32'(gnt), 32'h0001);
        for (int i = 0; i < 9; i++) cycle();
        chk("s3_second", 32'(s), 32'd15);
        for (int i = 0; i < 9; i++) cycle();
        chk("s3_wrap", 32'(gnt), 32'h0001);

        // Requester 3 with rdy pattern 1,0,0 repeating
        req = 16'h0000;
        do_reset();
        req = 16'h0008; rdy = 1'b0;
        cycle();
        ycount = 0;
        begin
            bit released;
            released = 0;
            for (int k = 0; k < 40 && !released; k++) begin
                rdy = (k % 3 == 0);
                cycle();
                if (gnt == 16'h0) released = 1;
            end
            chk("s4_released", 32'(released), 32'd1);
        end
        chk("s4_pulses", 32'(ycount), 32'd8);

        // Requester 7 drops after three beats; 11 is next from 8 upward
        req = 16'h0000; rdy = 1'b1;
        do_reset();
        req = 16'h0080;
        cycle();
        req = 16'h0884;
        ycount = 0;
        for (int i = 0; i < 3; i++) cycle();
        req = 16'h0804;
        cycle();
        chk("s5_drop_gnt", 32'(gnt), 32'h0);
        chk("s5_pulses", 32'(ycount), 32'd3);
        cycle();
        chk("s5_next", 32'(s), 32'd11);

        // Reset mid-grant of 9 after five beats; post-reset scan starts at 0
        req = 16'h0000;
        cycle();
        cycle();
        req = 16'h0200;
        cycle();
        chk("s6_grant9", 32'(gnt), 32'h0200);
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1;
        cycle();
        chk("s6_rst_gnt", 32'(gnt), 32'h0);
        chk("s6_rst_yv", 32'(y_valid), 32'd0);
        rst = 1'b0; req = 16'h0204;
        cycle();
        chk("s6_post_rst", 32'(s), 32'd2);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 15)] = ~req[$urandom_range(0, 15)];
            if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 15)] = 1'b0;
            if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 15)] = 1'b1;
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
